// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the 5-stage MIPS pipeline control.
//   - Opcode encodings decoded by the hazard sequencer.
//   - Hazard sequencer FSM state encoding.
//   - ALU operand forwarding select codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // ALU operand select: regfile, EX/MEM forward, MEM/WB forward.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: combinational ALU operand forwarding selects.
//   Compares the EX-stage source registers against the EX/MEM and MEM/WB
//   destinations. The younger EX/MEM result wins when both match.
//   Register $0 never forwards.
// Ports:
//   ex_rs, ex_rt     in  REG_W  source registers of the instruction in EX
//   mem_regwrite     in  1      EX/MEM writer valid
//   mem_rd           in  REG_W  EX/MEM destination
//   wb_regwrite      in  1      MEM/WB writer valid
//   wb_rd            in  REG_W  MEM/WB destination
//   fwd_a, fwd_b     out 2      operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
module fwd_unit
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic mem_ok;
  logic wb_ok;

  always_comb begin
    mem_ok = mem_regwrite && (mem_rd != '0);
    wb_ok  = wb_regwrite && (wb_rd != '0);

    fwd_a = FWD_RF;
    if (mem_ok && (mem_rd == ex_rs))     fwd_a = FWD_EXMEM;
    else if (wb_ok && (wb_rd == ex_rs))  fwd_a = FWD_MEMWB;

    fwd_b = FWD_RF;
    if (mem_ok && (mem_rd == ex_rt))     fwd_b = FWD_EXMEM;
    else if (wb_ok && (wb_rd == ex_rt))  fwd_b = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage MIPS core.
//   Detects RAW hazards between the ID-stage sources and EX/MEM destinations,
//   stalls PC and IF/ID while bubbling ID/EX, and flushes younger stages when
//   a BEQ resolves taken in MEM (branch has priority over any stall).
//   Build option: define FORWARD_EN to instantiate fwd_unit; only load-use
//   hazards then stall (1 cycle). Without it fwd_a/fwd_b are constant 00,
//   wb_* are ignored and full RAW stalls are inserted (EX match 2, MEM match 1).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_opcode, id_rs, id_rt        instruction in ID
//   ex_regwrite, ex_memread, ex_rd writer in EX
//   mem_regwrite, mem_rd           writer in MEM
//   mem_br_taken                   taken branch resolving in MEM
//   wb_regwrite, wb_rd             writer in WB (forwarding only)
//   pc_write, ifid_write           register enables (1 = load)
//   idex_bubble                    zero the ID/EX control bits
//   flush                          clear IF/ID, ID/EX, EX/MEM
//   fwd_a, fwd_b                   ALU operand selects
//   dbg_state                      current FSM state (RUN=0, STALL=1, FLUSH=2)
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_br_taken,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       dbg_state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uses_rs, uses_rt;
  logic             ex_hit;
  logic [CNT_W-1:0] need;

  assign dbg_state = state_q;

  // Which ID fields are real sources; unknown opcodes behave as NOP.
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_SW, OP_BEQ: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_LW:   uses_rs = 1'b1;
      OP_NOP:  ;
      default: ;
    endcase
  end

  assign ex_hit = ex_regwrite && (ex_rd != '0) &&
                  ((uses_rs && (id_rs == ex_rd)) || (uses_rt && (id_rt == ex_rd)));

`ifdef FORWARD_EN
  // Only a load in EX cannot be forwarded in time.
  assign need = (ex_hit && ex_memread) ? CNT_W'(1) : '0;
`else
  logic mem_hit;
  assign mem_hit = mem_regwrite && (mem_rd != '0) &&
                   ((uses_rs && (id_rs == mem_rd)) || (uses_rt && (id_rt == mem_rd)));
  // WB writer is ignored: the regfile is write-first.
  assign need = ex_hit ? CNT_W'(2) : (mem_hit ? CNT_W'(1) : '0);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush       = 1'b0;

    if (mem_br_taken) begin
      // Branch target loads into PC; any stall in progress is abandoned.
      flush      = 1'b1;
      ifid_write = 1'b0;
      cnt_d      = '0;
      state_d    = ST_FLUSH;
    end else begin
      case (state_q)
        ST_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end
        default: begin
          // RUN and the single FLUSH cycle evaluate hazards identically.
          state_d = ST_RUN;
          cnt_d   = '0;
          if (need != '0) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (need > CNT_W'(1)) begin
              cnt_d   = need - CNT_W'(1);
              state_d = ST_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FORWARD_EN
  // Shadow of the ID/EX source fields; bubbles and flushes carry $0 so they
  // never forward. Non-source fields (e.g. LW rt) are also zeroed.
  logic [REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;

  always_comb begin
    ex_rs_d = '0;
    ex_rt_d = '0;
    if (!flush && !idex_bubble) begin
      if (uses_rs) ex_rs_d = id_rs;
      if (uses_rt) ex_rt_d = id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
    end
  end

  fwd_unit #(.REG_W(REG_W)) u_fwd (
    .ex_rs        (ex_rs_q),
    .ex_rt        (ex_rt_q),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  logic unused_inputs;
  assign unused_inputs = ^{ex_memread, wb_regwrite, wb_rd};
`endif

endmodule
